// File: rtl/bridge_target_cmd_window.sv
// APF target-command window: publishes one arbitrated request (command word plus param block)
// on the bridge bus, waits for the host "ok" acknowledge or a timeout, then pulses done with a result.
module bridge_target_cmd_window #(
  parameter logic [31:0] BASE_ADDR      = 32'hF800_2000,
  parameter logic [31:0] PARAM_OFFSET   = 32'h0000_0020,
  parameter int          PARAM_WORDS    = 8,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  input  logic [15:0]               req_word,
  input  logic [32*PARAM_WORDS-1:0] req_param,
  output logic                      req_done,
  output logic [31:0]               req_result,
  input  logic [31:0]               bridge_addr,
  input  logic                      bridge_wr,
  input  logic [31:0]               bridge_wr_data,
  input  logic                      bridge_rd,
  output logic [31:0]               bridge_rd_data,
  output logic                      busy
);

  localparam logic [15:0] CMD_TAG        = 16'h636D;
  localparam logic [15:0] ACK_TAG        = 16'h6F6B;
  localparam logic [31:0] PARAM_BASE_IDX = PARAM_OFFSET >> 2;
  localparam int          CW             = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT     = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  state_e                        state_q;
  logic [31:0]                   status_q;
  logic [PARAM_WORDS-1:0][31:0]  param_q;
  logic [CW-1:0]                 tmo_cnt_q;
  logic                          req_done_q;
  logic [31:0]                   req_result_q;
  logic [31:0]                   rd_data_q;
  logic                          busy_q;

  logic [31:0]   offset_s;
  logic [31:0]   word_idx_s;
  logic          status_hit_s;
  logic          ack_wr_s;
  logic          timeout_hit_s;
  logic [CW-1:0] tmo_cnt_d;
  logic [31:0]   rd_mux_s;

  // Address decode relative to the window base; the low two byte-address bits drop out in the shift.
  assign offset_s      = bridge_addr - BASE_ADDR;
  assign word_idx_s    = offset_s >> 2;
  assign status_hit_s  = (word_idx_s == 32'h0);
  assign ack_wr_s      = bridge_wr && status_hit_s && (bridge_wr_data[31:16] == ACK_TAG);
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && ((tmo_cnt_q + CW'(1)) == TO_LIMIT);
  assign tmo_cnt_d     = (TIMEOUT_CYCLES != 0) ? (tmo_cnt_q + CW'(1)) : tmo_cnt_q;

  // Read mux: status word or one of the frozen param words; anything else reads zero.
  always_comb begin
    rd_mux_s = 32'h0;
    if (status_hit_s) begin
      rd_mux_s = status_q;
    end else begin
      for (int i = 0; i < PARAM_WORDS; i++) begin
        rd_mux_s = rd_mux_s | ({32{word_idx_s == (PARAM_BASE_IDX + 32'(i))}} & param_q[i]);
      end
    end
  end

  // Request FSM with registered status, param copy, completion and read-data outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      status_q     <= 32'h0;
      param_q      <= {PARAM_WORDS{32'h0}};
      tmo_cnt_q    <= {CW{1'b0}};
      req_done_q   <= 1'b0;
      req_result_q <= 32'h0;
      rd_data_q    <= 32'h0;
      busy_q       <= 1'b0;
    end else begin
      req_done_q   <= 1'b0;
      req_result_q <= 32'h0;
      // Read samples the pre-write status so a same-cycle write is not visible yet.
      if (bridge_rd) begin
        rd_data_q <= rd_mux_s;
      end
      case (state_q)
        ST_IDLE: begin
          tmo_cnt_q <= {CW{1'b0}};
          if (req_valid) begin
            status_q <= {CMD_TAG, req_word};
            param_q  <= req_param;
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT_ACK;
          end else begin
            status_q <= 32'h0;
            busy_q   <= 1'b0;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_wr_s) begin
            status_q     <= bridge_wr_data;
            req_done_q   <= 1'b1;
            req_result_q <= {16'h0, bridge_wr_data[15:0]};
            state_q      <= ST_DONE;
          end else if (timeout_hit_s) begin
            req_done_q   <= 1'b1;
            req_result_q <= 32'hFFFF_FFFF;
            state_q      <= ST_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        ST_DONE: begin
          status_q <= 32'h0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          status_q <= 32'h0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_done       = req_done_q;
  assign req_result     = req_result_q;
  assign bridge_rd_data = rd_data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_bridge_target_cmd_window.sv
// Scoreboard bench for bridge_target_cmd_window: stimulus pushes expected read data and
// completion results into queues, a monitor pops and compares them as the DUT presents them.
module tb_bridge_target_cmd_window;

  localparam logic [31:0] BASE = 32'hF800_2000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [15:0]  req_word = 16'h0;
  logic [255:0] req_param = 256'h0;
  logic         req_done;
  logic [31:0]  req_result;
  logic [31:0]  bridge_addr = 32'h0;
  logic         bridge_wr = 1'b0;
  logic [31:0]  bridge_wr_data = 32'h0;
  logic         bridge_rd = 1'b0;
  logic [31:0]  bridge_rd_data;
  logic         busy;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_done[$];
  logic rd_pend = 1'b0;

  bridge_target_cmd_window #(
    .BASE_ADDR(32'hF800_2000),
    .PARAM_OFFSET(32'h0000_0020),
    .PARAM_WORDS(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_word(req_word), .req_param(req_param),
    .req_done(req_done), .req_result(req_result),
    .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
    .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    exp_rd.push_back(exp);
    bridge_addr = addr;
    bridge_rd = 1'b1;
    cyc();
    bridge_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bridge_addr = addr;
    bridge_wr_data = data;
    bridge_wr = 1'b1;
    cyc();
    bridge_wr = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp);
    exp_rd.push_back(exp);
    bridge_addr = addr;
    bridge_wr_data = data;
    bridge_wr = 1'b1;
    bridge_rd = 1'b1;
    cyc();
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
  endtask

  always @(posedge clk) rd_pend <= bridge_rd;

  // Monitor: compares read data and completion pulses against the queued expectations.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", bridge_rd_data, 32'h0000_0000);
      else chk("rd_data", bridge_rd_data, exp_rd.pop_front());
    end
    if (req_done === 1'b1) begin
      if (exp_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got req_done=1 result %h expected no pulse", req_result);
      end else begin
        chk("done_result", req_result, exp_done.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, req_done}, 32'h0);
    chk("reset_result", req_result, 32'h0);
    chk("reset_rd_data", bridge_rd_data, 32'h0);
    reset_n = 1'b1;
    cyc();
    rd(BASE, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // Basic request, frozen params, read-only params, ack
    req_word = 16'h0140;
    for (int i = 0; i < 8; i++) req_param[32*i +: 32] = 32'hA0 + 32'(i);
    req_param[31:0] = 32'h0000_0003;
    req_valid = 1'b1;
    cyc();
    req_param[31:0] = 32'hDEAD_BEEF;
    chk("t2_busy", {31'h0, busy}, 32'h1);
    rd(BASE, 32'h636D_0140);
    rd(BASE + 32'h20, 32'h0000_0003);
    rd(BASE + 32'h3C, 32'h0000_00A7);
    rd(BASE + 32'h40, 32'h0);
    rd(BASE + 32'h04, 32'h0);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    rd(BASE + 32'h23, 32'h0000_0003);
    exp_done.push_back(32'h0000_0002);
    wr(BASE, 32'h6F6B_0002);
    req_valid = 1'b0;
    rd(BASE, 32'h6F6B_0002);
    rd(BASE, 32'h0);
    chk("t2_busy_after", {31'h0, busy}, 32'h0);

    // Non-ok upper half ignored; simultaneous read sees pre-write status
    req_word = 16'h0155;
    req_valid = 1'b1;
    cyc();
    rdwr(BASE, 32'h1234_0000, 32'h636D_0155);
    chk("t3_still_busy", {31'h0, busy}, 32'h1);
    rd(BASE, 32'h636D_0155);
    exp_done.push_back(32'h0);
    rdwr(BASE, 32'h6F6B_0000, 32'h636D_0155);
    req_valid = 1'b0;
    cyc();
    chk("t3_busy_after", {31'h0, busy}, 32'h0);

    // Timeout without ack
    req_word = 16'h0777;
    req_valid = 1'b1;
    cyc();
    exp_done.push_back(32'hFFFF_FFFF);
    n = 0;
    while (req_done !== 1'b1 && n < 150) begin
      cyc();
      n++;
    end
    total++;
    if (n < 100 || n > 101) begin
      bad++;
      $display("FAIL t4_timeout_latency: got %0d cycles expected 100..101", n);
    end
    req_valid = 1'b0;
    cyc();

    // Back-to-back requests; ack in the acceptance cycle is ignored
    req_word = 16'h0201;
    req_valid = 1'b1;
    cyc();
    exp_done.push_back(32'h0000_0011);
    wr(BASE, 32'h6F6B_0011);
    req_valid = 1'b0;
    cyc();
    req_word = 16'h0202;
    req_param[31:0] = 32'h0000_0055;
    req_valid = 1'b1;
    wr(BASE, 32'h6F6B_0099);
    chk("t5_busy", {31'h0, busy}, 32'h1);
    rd(BASE, 32'h636D_0202);
    rd(BASE + 32'h20, 32'h0000_0055);
    exp_done.push_back(32'h0000_0022);
    wr(BASE, 32'h6F6B_0022);
    req_valid = 1'b0;
    cyc();
    chk("t5_busy_after", {31'h0, busy}, 32'h0);

    // Reset mid-request
    req_word = 16'h0303;
    req_valid = 1'b1;
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_busy_async", {31'h0, busy}, 32'h0);
    req_valid = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    rd(BASE, 32'h0);
    rd(BASE + 32'h20, 32'h0);
    chk("t6_busy_after", {31'h0, busy}, 32'h0);

    repeat (3) cyc();
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
